alarm_sequencer: RTL and testbench
==================================

// Module: alarm_sequencer
// PURPOSE
//  Sequences the alarm bell after the alarm-time comparator. Arms on bell enable and
//  starts ringing on a rising edge of the time-match flag. Handles snooze, stop and
//  ring timeout, and generates the alternating 1 kHz / 500 Hz tone per second.
//  Sits between the set-time comparators/timekeeper and the buzzer pin.
// PARAMETERS
//  RING_SECS    60   seconds of unattended ringing before auto-stop
//  SNOOZE_SECS  300  seconds of silence per snooze
//  MAX_SNOOZE   3    snoozes allowed per alarm event; further snooze acts as stop
//  CNT_W        9    width of seconds counter; must hold max(RING_SECS,SNOOZE_SECS)
// PORTS
//  clk          in   1      2 kHz system clock, sole clock
//  rst          in   1      asynchronous, active-high reset
//  sec_tick     in   1      1-cycle pulse once per second, sync to clk
//  time_match   in   1      alarm HH:MM equals current HH:MM (level)
//  bell_en      in   1      alarm enable switch (level)
//  snooze_key   in   1      debounced snooze key (level, active-high)
//  stop_key     in   1      debounced stop key (level, active-high)
//  bell_out     out  1      tone to buzzer
//  ringing      out  1      high in RING
//  snoozing     out  1      high in SNOOZE
//  snooze_cnt   out  clog2(MAX_SNOOZE+1)  snoozes used in current event
//  state_o      out  3      encoded FSM state, for debug/display
// BEHAVIOUR
//  - Reset: state=IDLE, sec counter=0, snooze_cnt=0, tone divider=0, phase=0;
//    all outputs 0.
//  - Keys and time_match are rising-edge detected internally (prev-value regs,
//    reset 0). Actions fire one clk after the edge.
//  - States: IDLE=0, ARMED=1, RING=2, SNOOZE=3, DONE=4.
//  - IDLE: bell_en=1 -> ARMED.
//  - ARMED: time_match rise -> RING; sec_cnt=0, snooze_cnt=0, phase=0.
//    Level-high time_match at arming does not trigger.
//  - RING: stop rise -> DONE.
//    snooze rise with snooze_cnt<MAX_SNOOZE -> SNOOZE; sec_cnt=0, snooze_cnt++.
//    snooze rise with snooze_cnt==MAX_SNOOZE -> DONE.
//    Each sec_tick: sec_cnt++ and phase toggles.
//    sec_cnt reaching RING_SECS -> DONE.
//  - SNOOZE: each sec_tick sec_cnt++; reaching SNOOZE_SECS -> RING with sec_cnt=0,
//    phase=0. Entry does not depend on time_match. stop rise -> DONE.
//  - DONE: time_match=0 -> ARMED. Prevents retrigger in the same minute.
//  - bell_en=0 in any state -> IDLE next clk; bell_out=0 from that clk.
//    bell_en=0 has priority over everything.
//  - Priority in one cycle: bell_en=0 > stop > snooze > sec_tick/timeout.
//    A key edge on the same cycle as sec_tick suppresses that tick's count.
//  - Tone: 2-bit free-running divider d. tone_1k=d[0], tone_500=d[1].
//    bell_out = RING & (phase ? tone_500 : tone_1k), registered (1 clk latency).
//  - ringing, snoozing and state_o are decoded from registered state; no glitches.
//  - Reset mid-ring: bell_out=0 immediately (async); FSM returns to IDLE.
// STRUCTURE
//  - Shared package: state encodings (ST_IDLE..ST_DONE) and the 3-bit state width.
//  - One sub-module: edge_detect (rising-edge pulse, async active-high reset),
//    instantiated for snooze_key, stop_key and time_match.
//  - FSM, seconds counter, snooze counter and tone divider stay in this module.
// TESTING
//  1. Reset with bell_en=1 -> IDLE.
//     Release reset -> ARMED next clk; all outputs 0.
//  2. ARMED, time_match 0->1 -> RING.
//     bell_out toggles every clk (1 kHz) for the 1st second, every 2 clk after the
//     next sec_tick.
//     60 ticks -> DONE; time_match=0 -> ARMED.
//  3. RING, snooze rise -> SNOOZE, snooze_cnt=1.
//     300 ticks -> RING. Repeat to snooze_cnt=3.
//     4th snooze -> DONE, bell_out=0.
//  4. RING, stop and snooze rise on the same clk -> DONE; snooze_cnt unchanged.
//  5. RING, bell_en->0 -> IDLE next clk, bell_out=0.
//     bell_en->1 with time_match still high -> ARMED, no ring.
//  6. Assert rst mid-SNOOZE -> all outputs 0 asynchronously, state_o=0.

Source files
------------

// File: rtl/alarm_sequencer_pkg.sv
// Shared definitions for the alarm bell sequencer: FSM state encoding and tone helper.
package alarm_sequencer_pkg;

   localparam int STATE_W = 3;

   // Encodings are visible on state_o for debug/display, so they are fixed values.
   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_ARMED  = 3'd1,
      ST_RING   = 3'd2,
      ST_SNOOZE = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   // Select the tone bit from the divider: phase 0 -> 1 kHz (d[0]), phase 1 -> 500 Hz (d[1]).
   function automatic logic tone_sel(input logic phase, input logic [1:0] div);
      return phase ? div[1] : div[0];
   endfunction

endpackage : alarm_sequencer_pkg

// File: rtl/alarm_sequencer_edge_detect.sv
// Rising-edge detector: one-cycle pulse when i_level goes 0->1. Previous value resets to 0.
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic i_level,
   output logic o_rise
);

   logic r_prev;

   // Remember last cycle's level so a rise can be seen against it.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prev <= 1'b0;
      end else begin
         r_prev <= i_level;
      end
   end

   assign o_rise = i_level & ~r_prev;

endmodule : edge_detect

// File: rtl/alarm_sequencer.sv
// Alarm bell sequencer: arms on bell enable, rings on a rising time match, and handles
// snooze, stop, ring timeout and the alternating 1 kHz / 500 Hz buzzer tone.
module alarm_sequencer
   import alarm_sequencer_pkg::*;
#(
   parameter  int RING_SECS   = 60,
   parameter  int SNOOZE_SECS = 300,
   parameter  int MAX_SNOOZE  = 3,
   parameter  int CNT_W       = 9,
   localparam int SNZ_W       = $clog2(MAX_SNOOZE + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sec_tick,
   input  logic               time_match,
   input  logic               bell_en,
   input  logic               snooze_key,
   input  logic               stop_key,
   output logic               bell_out,
   output logic               ringing,
   output logic               snoozing,
   output logic [SNZ_W-1:0]   snooze_cnt,
   output logic [STATE_W-1:0] state_o
);

   localparam logic [CNT_W-1:0] RING_LIM   = CNT_W'(RING_SECS);
   localparam logic [CNT_W-1:0] SNOOZE_LIM = CNT_W'(SNOOZE_SECS);
   localparam logic [SNZ_W-1:0] SNZ_MAX    = SNZ_W'(MAX_SNOOZE);

   // Registered state
   state_t           r_state;
   logic [CNT_W-1:0] r_sec_cnt;
   logic [SNZ_W-1:0] r_snooze_cnt;
   logic [1:0]       r_div;
   logic             r_phase;
   logic             r_bell;

   // Next-state values
   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_sec_cnt_nxt;
   logic [SNZ_W-1:0] w_snooze_cnt_nxt;
   logic             w_phase_nxt;

   // Edge pulses and helpers
   logic             w_snooze_rise;
   logic             w_stop_rise;
   logic             w_match_rise;
   logic             w_tick;
   logic [CNT_W-1:0] w_sec_inc;

   edge_detect u_snooze_edge (
      .clk     (clk),
      .rst     (rst),
      .i_level (snooze_key),
      .o_rise  (w_snooze_rise)
   );

   edge_detect u_stop_edge (
      .clk     (clk),
      .rst     (rst),
      .i_level (stop_key),
      .o_rise  (w_stop_rise)
   );

   edge_detect u_match_edge (
      .clk     (clk),
      .rst     (rst),
      .i_level (time_match),
      .o_rise  (w_match_rise)
   );

   // A key edge in the same cycle as a second tick swallows that tick.
   assign w_tick    = sec_tick & ~(w_snooze_rise | w_stop_rise);
   assign w_sec_inc = r_sec_cnt + 1'b1;

   // Next-state and counter updates; bell_en low overrides everything, then stop, snooze, tick.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_state_nxt      = r_state;
      w_sec_cnt_nxt    = r_sec_cnt;
      w_snooze_cnt_nxt = r_snooze_cnt;
      w_phase_nxt      = r_phase;

      if (!bell_en) begin
         w_state_nxt = ST_IDLE;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               w_state_nxt = ST_ARMED;
            end

            // Only a fresh rise counts, so a match already high at arming is ignored.
            ST_ARMED: begin
               if (w_match_rise) begin
                  w_state_nxt      = ST_RING;
                  w_sec_cnt_nxt    = '0;
                  w_snooze_cnt_nxt = '0;
                  w_phase_nxt      = 1'b0;
               end
            end

            ST_RING: begin
               if (w_stop_rise) begin
                  w_state_nxt = ST_DONE;
               end else if (w_snooze_rise) begin
                  if (r_snooze_cnt < SNZ_MAX) begin
                     w_state_nxt      = ST_SNOOZE;
                     w_sec_cnt_nxt    = '0;
                     w_snooze_cnt_nxt = r_snooze_cnt + 1'b1;
                  end else begin
                     // Snooze budget exhausted: treat as stop.
                     w_state_nxt = ST_DONE;
                  end
               end else if (sec_tick) begin
                  w_sec_cnt_nxt = w_sec_inc;
                  w_phase_nxt   = ~r_phase;
                  if (w_sec_inc == RING_LIM) begin
                     w_state_nxt = ST_DONE;
                  end
               end
            end

            // Snooze expiry re-rings regardless of time_match.
            ST_SNOOZE: begin
               if (w_stop_rise) begin
                  w_state_nxt = ST_DONE;
               end else if (w_tick) begin
                  if (w_sec_inc == SNOOZE_LIM) begin
                     w_state_nxt   = ST_RING;
                     w_sec_cnt_nxt = '0;
                     w_phase_nxt   = 1'b0;
                  end else begin
                     w_sec_cnt_nxt = w_sec_inc;
                  end
               end
            end

            // Wait for the matching minute to pass so the alarm cannot retrigger.
            ST_DONE: begin
               if (!time_match) begin
                  w_state_nxt = ST_ARMED;
               end
            end

            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // FSM state and counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_sec_cnt    <= '0;
         r_snooze_cnt <= '0;
         r_phase      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_sec_cnt    <= w_sec_cnt_nxt;
         r_snooze_cnt <= w_snooze_cnt_nxt;
         r_phase      <= w_phase_nxt;
      end
   end

   // Free-running 2-bit tone divider: d[0] is 1 kHz, d[1] is 500 Hz at a 2 kHz clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div <= 2'd0;
      end else begin
         r_div <= r_div + 2'd1;
      end
   end

   // Registered buzzer output; gated by the state being entered so the bell is silent
   // from the same edge that leaves RING (stop, snooze, timeout or bell_en low).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bell <= 1'b0;
      end else begin
         r_bell <= (w_state_nxt == ST_RING) & tone_sel(w_phase_nxt, r_div);
      end
   end

   assign bell_out   = r_bell;
   assign ringing    = (r_state == ST_RING);
   assign snoozing   = (r_state == ST_SNOOZE);
   assign snooze_cnt = r_snooze_cnt;
   assign state_o    = r_state;

endmodule : alarm_sequencer

// File: tb/tb_alarm_sequencer.sv
// Self-checking bench for alarm_sequencer: directed scenarios followed by random stimulus,
// every cycle compared against a behavioural model of the alarm rules.
module tb_alarm_sequencer;

   localparam int RING_SECS   = 60;
   localparam int SNOOZE_SECS = 300;
   localparam int MAX_SNOOZE  = 3;

   localparam int S_IDLE   = 0;
   localparam int S_ARMED  = 1;
   localparam int S_RING   = 2;
   localparam int S_SNOOZE = 3;
   localparam int S_DONE   = 4;

   logic       clk        = 1'b0;
   logic       rst        = 1'b1;
   logic       sec_tick   = 1'b0;
   logic       time_match = 1'b0;
   logic       bell_en    = 1'b0;
   logic       snooze_key = 1'b0;
   logic       stop_key   = 1'b0;
   logic       bell_out;
   logic       ringing;
   logic       snoozing;
   logic [1:0] snooze_cnt;
   logic [2:0] state_o;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model state
   int m_state;
   int m_secs;
   int m_snz;
   int m_cyc;
   bit m_slow;
   bit m_bell;
   bit m_prev_match;
   bit m_prev_snz;
   bit m_prev_stop;

   alarm_sequencer #(
      .RING_SECS   (RING_SECS),
      .SNOOZE_SECS (SNOOZE_SECS),
      .MAX_SNOOZE  (MAX_SNOOZE),
      .CNT_W       (9)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sec_tick   (sec_tick),
      .time_match (time_match),
      .bell_en    (bell_en),
      .snooze_key (snooze_key),
      .stop_key   (stop_key),
      .bell_out   (bell_out),
      .ringing    (ringing),
      .snoozing   (snoozing),
      .snooze_cnt (snooze_cnt),
      .state_o    (state_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state      = S_IDLE;
      m_secs       = 0;
      m_snz        = 0;
      m_cyc        = 0;
      m_slow       = 1'b0;
      m_bell       = 1'b0;
      m_prev_match = 1'b0;
      m_prev_snz   = 1'b0;
      m_prev_stop  = 1'b0;
   endtask

   // One clock of alarm behaviour, evaluated from the inputs present before the edge.
   task automatic model_step();
      bit up_match;
      bit up_snz;
      bit up_stop;
      int d;
      up_match = time_match && !m_prev_match;
      up_snz   = snooze_key && !m_prev_snz;
      up_stop  = stop_key && !m_prev_stop;
      d        = m_cyc % 4;
      if (!bell_en) begin
         m_state = S_IDLE;
      end else if (m_state == S_IDLE) begin
         m_state = S_ARMED;
      end else if (m_state == S_ARMED) begin
         if (up_match) begin
            m_state = S_RING;
            m_secs  = 0;
            m_snz   = 0;
            m_slow  = 1'b0;
         end
      end else if (m_state == S_RING) begin
         if (up_stop) begin
            m_state = S_DONE;
         end else if (up_snz) begin
            if (m_snz < MAX_SNOOZE) begin
               m_state = S_SNOOZE;
               m_secs  = 0;
               m_snz   = m_snz + 1;
            end else begin
               m_state = S_DONE;
            end
         end else if (sec_tick) begin
            m_secs = m_secs + 1;
            m_slow = !m_slow;
            if (m_secs == RING_SECS) m_state = S_DONE;
         end
      end else if (m_state == S_SNOOZE) begin
         if (up_stop) begin
            m_state = S_DONE;
         end else if (sec_tick && !up_snz) begin
            m_secs = m_secs + 1;
            if (m_secs == SNOOZE_SECS) begin
               m_state = S_RING;
               m_secs  = 0;
               m_slow  = 1'b0;
            end
         end
      end else begin
         if (!time_match) m_state = S_ARMED;
      end
      m_bell       = (m_state == S_RING) && (m_slow ? ((d >> 1) & 1) != 0 : (d & 1) != 0);
      m_prev_match = time_match;
      m_prev_snz   = snooze_key;
      m_prev_stop  = stop_key;
      m_cyc        = m_cyc + 1;
   endtask

   task automatic compare_all();
      check("state_o",    state_o,    m_state);
      check("ringing",    ringing,    m_state == S_RING);
      check("snoozing",   snoozing,   m_state == S_SNOOZE);
      check("snooze_cnt", snooze_cnt, m_snz);
      check("bell_out",   bell_out,   m_bell);
   endtask

   task automatic cycle();
      if (rst) model_reset();
      else     model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         sec_tick = 1'b1;
         cycle();
         sec_tick = 1'b0;
         cycle();
      end
   endtask

   task automatic press_snooze();
      snooze_key = 1'b1;
      cycle();
      snooze_key = 1'b0;
      cycle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // 1. Reset held with bell_en high, then release.
      bell_en = 1'b1;
      model_reset();
      #2;
      compare_all();
      cycle();
      cycle();
      check("reset_state", state_o, S_IDLE);
      rst = 1'b0;
      cycle();
      check("armed_after_reset", state_o, S_ARMED);
      check("armed_bell", bell_out, 0);

      // 2. Time match rise rings; tone and timeout.
      time_match = 1'b1;
      cycle();
      check("ring_on_match", state_o, S_RING);
      for (int i = 0; i < 6; i++) cycle();
      ticks(RING_SECS - 1);
      check("ring_before_timeout", state_o, S_RING);
      for (int i = 0; i < 6; i++) cycle();
      ticks(1);
      check("ring_timeout", state_o, S_DONE);
      check("timeout_bell", bell_out, 0);
      cycle();
      check("done_holds", state_o, S_DONE);
      time_match = 1'b0;
      cycle();
      check("rearm_after_done", state_o, S_ARMED);

      // 3. Snooze three times, fourth snooze stops.
      time_match = 1'b1;
      cycle();
      for (int s = 1; s <= MAX_SNOOZE; s++) begin
         press_snooze();
         check("snooze_state", state_o, S_SNOOZE);
         check("snooze_count", snooze_cnt, s);
         ticks(SNOOZE_SECS - 1);
         check("snooze_before_expiry", state_o, S_SNOOZE);
         ticks(1);
         check("snooze_expiry", state_o, S_RING);
         for (int i = 0; i < 4; i++) cycle();
      end
      snooze_key = 1'b1;
      cycle();
      check("fourth_snooze_done", state_o, S_DONE);
      check("fourth_snooze_bell", bell_out, 0);
      check("fourth_snooze_cnt", snooze_cnt, 3);
      snooze_key = 1'b0;
      time_match = 1'b0;
      cycle();

      // 4. Stop and snooze on the same clock.
      time_match = 1'b1;
      cycle();
      press_snooze();
      ticks(SNOOZE_SECS);
      check("back_to_ring", state_o, S_RING);
      snooze_key = 1'b1;
      stop_key   = 1'b1;
      sec_tick   = 1'b1;
      cycle();
      check("stop_wins", state_o, S_DONE);
      check("stop_wins_cnt", snooze_cnt, 1);
      snooze_key = 1'b0;
      stop_key   = 1'b0;
      sec_tick   = 1'b0;
      time_match = 1'b0;
      cycle();

      // 5. bell_en drop mid-ring, re-enable while match still high.
      time_match = 1'b1;
      cycle();
      cycle();
      bell_en = 1'b0;
      cycle();
      check("disable_idle", state_o, S_IDLE);
      check("disable_bell", bell_out, 0);
      bell_en = 1'b1;
      cycle();
      for (int i = 0; i < 4; i++) cycle();
      check("no_retrigger", state_o, S_ARMED);
      check("no_retrigger_ring", ringing, 0);

      // 6. Asynchronous reset while snoozing.
      time_match = 1'b0;
      cycle();
      time_match = 1'b1;
      cycle();
      press_snooze();
      ticks(3);
      check("pre_reset_snooze", state_o, S_SNOOZE);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check("async_state", state_o, S_IDLE);
      check("async_snoozing", snoozing, 0);
      check("async_cnt", snooze_cnt, 0);
      check("async_bell", bell_out, 0);
      cycle();
      rst = 1'b0;
      cycle();
      check("post_reset_armed", state_o, S_ARMED);

      // Random stimulus against the model.
      for (int i = 0; i < 4000; i++) begin
         bell_en = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 39) == 0) time_match = ~time_match;
         if ($urandom_range(0, 19) == 0) snooze_key = ~snooze_key;
         if ($urandom_range(0, 59) == 0) stop_key = ~stop_key;
         sec_tick = ($urandom_range(0, 2) == 0);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_alarm_sequencer
